// File: rtl/t02_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// t02_mem_arbiter_if
// Bus bundle between the CPU fetch/data ports, the shared RAM port and the
// t02_mem_arbiter that multiplexes them.
//
// Signals:
//   imemRen, imemaddr              fetch request / address (held until i_ready)
//   dmmRen, dmmWen, dmmaddr,       data read / write request, address and
//   dmmstore                       store data (held until d_ready)
//   busy_o, ramload                RAM busy flag and read data
//   i_ready, d_ready               one-cycle completion pulses
//   Ren, Wen, ramaddr, ramstore    registered RAM command
//   imemload, dmmload              registered load data
//   timeout_err                    sticky access-timeout flag
//
// Modports:
//   slave  - the arbiter's view (requests and RAM status in, commands out)
//   master - the environment's view (CPU + RAM side)
// -----------------------------------------------------------------------------
interface t02_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              imemRen;
    logic [ADDR_W-1:0] imemaddr;
    logic              dmmRen;
    logic              dmmWen;
    logic [ADDR_W-1:0] dmmaddr;
    logic [DATA_W-1:0] dmmstore;
    logic              busy_o;
    logic [DATA_W-1:0] ramload;
    logic              i_ready;
    logic              d_ready;
    logic              Ren;
    logic              Wen;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] imemload;
    logic [DATA_W-1:0] dmmload;
    logic              timeout_err;

    modport slave (
        input  imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore,
        input  busy_o, ramload,
        output i_ready, d_ready, Ren, Wen, ramaddr, ramstore,
        output imemload, dmmload, timeout_err
    );

    modport master (
        output imemRen, imemaddr, dmmRen, dmmWen, dmmaddr, dmmstore,
        output busy_o, ramload,
        input  i_ready, d_ready, Ren, Wen, ramaddr, ramstore,
        input  imemload, dmmload, timeout_err
    );
endinterface

// File: rtl/t02_mem_arbiter.sv
// -----------------------------------------------------------------------------
// t02_mem_arbiter
// Registered arbiter between the CPU instruction-fetch port, the CPU data port
// and one shared RAM port. A 3-state FSM (IDLE -> ACCESS -> DONE) grants one
// request at a time, latching owner, operation, address and store data so the
// RAM sees stable values for the whole access. Data requests win over fetches
// (read before write); a starvation counter promotes a fetch that has been
// held off for STARVE_LIMIT consecutive data grants.
//
// Ports:
//   CLK   - system clock, rising edge
//   nRST  - asynchronous active-low reset
//   bus   - t02_mem_arbiter_if.slave bundle (requests, RAM port, ready pulses,
//           load registers, timeout_err)
//
// Parameters:
//   ADDR_W, DATA_W  - bus widths (must match the interface instance)
//   STARVE_LIMIT    - data grants tolerated while a fetch waits; 0 disables
//   TIMEOUT_CYCLES  - ACCESS cycle limit, only with T02_MEM_ARB_TIMEOUT_EN
//
// Optional feature: define T02_MEM_ARB_TIMEOUT_EN to abort accesses that stay
// busy for TIMEOUT_CYCLES ACCESS cycles and raise sticky timeout_err. Without
// it the FSM waits on busy_o indefinitely and timeout_err is tied to 0.
// -----------------------------------------------------------------------------
module t02_mem_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             CLK,
    input  logic             nRST,
    t02_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    // A zero limit still needs a 1-bit counter so the logic elaborates.
    localparam int unsigned     SC_W       = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SC_W-1:0] SC_MAX     = SC_W'(STARVE_LIMIT);
    localparam logic            PROMOTE_EN = (STARVE_LIMIT > 0);

    state_t          state;
    owner_t          owner;
    logic            op_wr;       // latched operation: 1 = write
    logic            first;       // first ACCESS cycle, busy_o not yet valid
    logic [SC_W-1:0] starve_cnt;

    owner_t grant_owner;
    logic   grant_wr;
    logic   grant_any;
    logic   promote;
    logic   access_end;
    logic   access_abort;

    // Grant selection and normal end-of-access detection.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can
        // leave a value unassigned and infer a latch.
        grant_owner = OWN_FETCH;
        grant_wr    = 1'b0;
        grant_any   = bus.imemRen | bus.dmmRen | bus.dmmWen;
        promote     = PROMOTE_EN && bus.imemRen && (starve_cnt >= SC_MAX);
        if (!promote) begin
            if (bus.dmmRen) begin
                grant_owner = OWN_DATA;
            end else if (bus.dmmWen) begin
                grant_owner = OWN_DATA;
                grant_wr    = 1'b1;
            end
        end
        access_end = (state == ACCESS) && !first && !bus.busy_o;
    end

`ifdef T02_MEM_ARB_TIMEOUT_EN
    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;      // ACCESS cycles already completed

    // During the TIMEOUT_CYCLES-th ACCESS cycle to_cnt equals TIMEOUT_CYCLES-1;
    // if the RAM has not finished by that edge the access is abandoned.
    assign access_abort = (state == ACCESS) && !access_end && (to_cnt == TO_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            to_cnt          <= '0;
            bus.timeout_err <= 1'b0;
        end else begin
            to_cnt <= (state == ACCESS && !access_end && !access_abort) ? to_cnt + 1'b1 : '0;
            if (access_abort) begin
                bus.timeout_err <= 1'b1;
            end
        end
    end
`else
    assign access_abort    = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Main FSM with all RAM-side and CPU-side outputs registered.
    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: the load registers are reset along with the control state so
        // every output reads 0 after reset and an abandoned access leaves no
        // stale data behind.
        if (!nRST) begin
            state        <= IDLE;
            owner        <= OWN_FETCH;
            op_wr        <= 1'b0;
            first        <= 1'b0;
            starve_cnt   <= '0;
            bus.i_ready  <= 1'b0;
            bus.d_ready  <= 1'b0;
            bus.Ren      <= 1'b0;
            bus.Wen      <= 1'b0;
            bus.ramaddr  <= '0;
            bus.ramstore <= '0;
            bus.imemload <= '0;
            bus.dmmload  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge register values regardless of statement order.
            bus.i_ready <= 1'b0;
            bus.d_ready <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner <= grant_owner;
                        op_wr <= grant_wr;
                        first <= 1'b1;
                        state <= ACCESS;
                        if (grant_owner == OWN_DATA) begin
                            bus.ramaddr <= bus.dmmaddr;
                            bus.Ren     <= !grant_wr;
                            bus.Wen     <= grant_wr;
                            if (grant_wr) begin
                                bus.ramstore <= bus.dmmstore;
                            end
                        end else begin
                            bus.ramaddr <= bus.imemaddr;
                            bus.Ren     <= 1'b1;
                            bus.Wen     <= 1'b0;
                        end
                    end
                    // A pending fetch counts the data grants that overtake it.
                    if (!bus.imemRen || grant_owner == OWN_FETCH) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != SC_MAX) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end

                ACCESS: begin
                    first <= 1'b0;
                    if (access_end || access_abort) begin
                        state       <= DONE;
                        bus.Ren     <= 1'b0;
                        bus.Wen     <= 1'b0;
                        bus.ramaddr <= {ADDR_W{1'b0}};
                        // Ready only goes to a requester that is still waiting;
                        // the load register is updated either way.
                        if (owner == OWN_FETCH) begin
                            bus.i_ready  <= bus.imemRen;
                            bus.imemload <= access_abort ? {DATA_W{1'b0}} : bus.ramload;
                        end else begin
                            bus.d_ready <= op_wr ? bus.dmmWen : bus.dmmRen;
                            if (!op_wr) begin
                                bus.dmmload <= access_abort ? {DATA_W{1'b0}} : bus.ramload;
                            end
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_t02_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_t02_mem_arbiter
// Self-checking bench for t02_mem_arbiter. A RAM responder drives busy_o and
// ramload; a monitor pops the expected grant (owner/op/address/store data)
// from a scoreboard queue whenever a new access starts and checks that the
// RAM command stays stable for the whole access. Scenario tasks drive the
// requests and check ready pulses, latencies and load registers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_t02_mem_arbiter;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned STARVE_LIMIT   = 4;
    localparam int unsigned TIMEOUT_CYCLES = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    t02_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    t02_mem_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .STARVE_LIMIT  (STARVE_LIMIT),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK (clk),
        .nRST(rst_n),
        .bus (bus)
    );

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] store;
    } grant_t;

    grant_t exp_q[$];
    grant_t cur;
    logic   have_cur    = 1'b0;
    logic   prev_active = 1'b0;
    logic   mon_active;
    int     n_checks    = 0;
    int     n_pass      = 0;
    int     grant_cnt   = 0;

    // RAM responder controls
    int     busy_hold  = 0;     // busy cycles after the first ACCESS cycle
    logic   busy_stuck = 1'b0;
    int     acc_k      = 0;

    function automatic grant_t mk(input logic is_data, input logic wr,
                                  input logic [31:0] addr, input logic [31:0] store);
        grant_t g;
        g.is_data = is_data;
        g.wr      = wr;
        g.addr    = addr;
        g.store   = store;
        return g;
    endfunction

    function automatic logic [31:0] ram_val(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return (a * 32'd3) ^ 32'h5A5A_0000;
    endfunction

    // RAM model: busy_o low in the first ACCESS cycle (arbiter must ignore it),
    // high for busy_hold cycles, then low to finish.
    always @(negedge clk) begin
        if (bus.Ren || bus.Wen) acc_k = acc_k + 1;
        else                    acc_k = 0;
        if (busy_stuck)      bus.busy_o = 1'b1;
        else if (acc_k <= 1) bus.busy_o = 1'b0;
        else                 bus.busy_o = (acc_k <= 1 + busy_hold);
        bus.ramload = bus.Ren ? ram_val(bus.ramaddr) : 32'hBAD0_BAD0;
    end

    // Scoreboard monitor: each new access must match the next expected grant,
    // and the latched command must not move while the access is in flight.
    always @(negedge clk) begin
        mon_active = bus.Ren | bus.Wen;
        if (rst_n) begin
            if (mon_active && !prev_active) begin
                grant_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL grant_unexpected: got Ren=%b Wen=%b addr=%h, want no grant",
                             bus.Ren, bus.Wen, bus.ramaddr);
                    have_cur = 1'b0;
                end else begin
                    cur      = exp_q.pop_front();
                    have_cur = 1'b1;
                    if ({bus.Ren, bus.Wen} !== {!cur.wr, cur.wr} || bus.ramaddr !== cur.addr ||
                        (cur.wr && bus.ramstore !== cur.store))
                        $display("FAIL grant_order: got Ren=%b Wen=%b addr=%h store=%h, want wr=%b addr=%h store=%h",
                                 bus.Ren, bus.Wen, bus.ramaddr, bus.ramstore, cur.wr, cur.addr, cur.store);
                    else n_pass++;
                end
            end else if (mon_active && have_cur) begin
                n_checks++;
                if (bus.ramaddr !== cur.addr || (cur.wr && bus.ramstore !== cur.store))
                    $display("FAIL cmd_stable: got addr=%h store=%h, want addr=%h store=%h",
                             bus.ramaddr, bus.ramstore, cur.addr, cur.store);
                else n_pass++;
            end
        end
        prev_active = mon_active;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.Ren, bus.Wen, bus.i_ready, bus.d_ready, bus.timeout_err} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000",
                     {bus.Ren, bus.Wen, bus.i_ready, bus.d_ready, bus.timeout_err});
        else n_pass++;
        n_checks++;
        if (bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0)
            $display("FAIL reset_ram: got addr=%h store=%h want 0", bus.ramaddr, bus.ramstore);
        else n_pass++;
        n_checks++;
        if (bus.imemload !== 32'h0 || bus.dmmload !== 32'h0)
            $display("FAIL reset_load: got i=%h d=%h want 0", bus.imemload, bus.dmmload);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dut.state !== 2'd0 || bus.Ren !== 1'b0)
            $display("FAIL reset_idle: got state=%0d Ren=%b want 0 0", dut.state, bus.Ren);
        else n_pass++;
    endtask

    task automatic test_fetch();
        int ren_cyc = 0;
        int rdy     = 0;
        int rdy_at  = 0;
        busy_hold = 3;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h100, 32'h0));
        bus.imemaddr = 32'h100;
        bus.imemRen  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.Ren) ren_cyc++;
            if (bus.i_ready) begin
                rdy++;
                rdy_at = c;
                bus.imemRen = 1'b0;
            end
        end
        n_checks++;
        if (ren_cyc !== 5) $display("FAIL fetch_ren_cycles: got %0d want 5", ren_cyc); else n_pass++;
        n_checks++;
        if (rdy !== 1 || rdy_at !== 6)
            $display("FAIL fetch_ready: got count=%0d at=%0d want 1 at 6", rdy, rdy_at);
        else n_pass++;
        n_checks++;
        if (bus.imemload !== 32'hDEAD_BEEF)
            $display("FAIL fetch_load: got %h want deadbeef", bus.imemload);
        else n_pass++;
        n_checks++;
        if (bus.Ren !== 1'b0 || bus.ramaddr !== 32'h0)
            $display("FAIL fetch_idle: got Ren=%b addr=%h want 0 0", bus.Ren, bus.ramaddr);
        else n_pass++;
    endtask

    task automatic test_simul_rw();
        int   rdy     = 0;
        logic rd_first = 1'b0;
        busy_hold = 1;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h500, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b1, 32'h500, 32'h55AA_55AA));
        bus.dmmaddr  = 32'h500;
        bus.dmmstore = 32'h55AA_55AA;
        bus.dmmRen   = 1'b1;
        bus.dmmWen   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) rd_first = bus.Ren && !bus.Wen;
            if (bus.d_ready) begin
                rdy++;
                if (rdy == 1) bus.dmmRen = 1'b0;
                else          bus.dmmWen = 1'b0;
            end
        end
        n_checks++;
        if (rd_first !== 1'b1) $display("FAIL simul_read_first: got %b want 1", rd_first); else n_pass++;
        n_checks++;
        if (rdy !== 2) $display("FAIL simul_ready_count: got %0d want 2", rdy); else n_pass++;
        n_checks++;
        if (bus.dmmload !== ram_val(32'h500))
            $display("FAIL simul_load: got %h want %h", bus.dmmload, ram_val(32'h500));
        else n_pass++;
    endtask

    task automatic test_write_latch();
        int          rdy = 0;
        logic [31:0] dl0;
        dl0       = bus.dmmload;
        busy_hold = 2;
        exp_q.push_back(mk(1'b1, 1'b1, 32'h2000, 32'h1234_5678));
        bus.dmmaddr  = 32'h2000;
        bus.dmmstore = 32'h1234_5678;
        bus.dmmWen   = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.dmmaddr  = 32'hFFFF_0000;
                bus.dmmstore = 32'hCAFE_F00D;
            end
            if (c == 3) begin
                n_checks++;
                if ({bus.Ren, bus.Wen} !== 2'b01 || bus.ramaddr !== 32'h2000 || bus.ramstore !== 32'h1234_5678)
                    $display("FAIL write_latch: got RW=%b addr=%h store=%h want 01 2000 12345678",
                             {bus.Ren, bus.Wen}, bus.ramaddr, bus.ramstore);
                else n_pass++;
            end
            if (bus.d_ready) begin
                rdy++;
                bus.dmmWen = 1'b0;
            end
        end
        n_checks++;
        if (rdy !== 1) $display("FAIL write_ready: got %0d want 1", rdy); else n_pass++;
        n_checks++;
        if (bus.dmmload !== dl0) $display("FAIL write_dmmload: got %h want %h", bus.dmmload, dl0); else n_pass++;
    endtask

    task automatic test_starvation();
        int ir = 0;
        int dr = 0;
        int g0;
        int sc_peak = 0;
        g0        = grant_cnt;
        busy_hold = 0;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(1'b1, 1'b0, 32'h400, 32'h0));
        exp_q.push_back(mk(1'b0, 1'b0, 32'h300, 32'h0));
        exp_q.push_back(mk(1'b1, 1'b0, 32'h400, 32'h0));
        bus.imemaddr = 32'h300;
        bus.dmmaddr  = 32'h400;
        bus.imemRen  = 1'b1;
        bus.dmmRen   = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (int'(dut.starve_cnt) > sc_peak) sc_peak = int'(dut.starve_cnt);
            if (bus.i_ready) begin
                ir++;
                bus.imemRen = 1'b0;
            end
            if (bus.d_ready) begin
                dr++;
                if (grant_cnt - g0 >= 6) bus.dmmRen = 1'b0;
            end
        end
        n_checks++;
        if (ir !== 1 || dr !== 5) $display("FAIL starve_ready: got i=%0d d=%0d want 1 5", ir, dr); else n_pass++;
        n_checks++;
        if (sc_peak !== 4) $display("FAIL starve_peak: got %0d want 4", sc_peak); else n_pass++;
        n_checks++;
        if (dut.starve_cnt !== '0) $display("FAIL starve_clear: got %0d want 0", dut.starve_cnt); else n_pass++;
    endtask

    task automatic test_withdraw();
        int ir = 0;
        busy_hold = 2;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h600, 32'h0));
        bus.imemaddr = 32'h600;
        bus.imemRen  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 2) bus.imemRen = 1'b0;
            if (bus.i_ready) ir++;
        end
        n_checks++;
        if (ir !== 0) $display("FAIL withdraw_ready: got %0d want 0", ir); else n_pass++;
        n_checks++;
        if (bus.imemload !== ram_val(32'h600))
            $display("FAIL withdraw_load: got %h want %h", bus.imemload, ram_val(32'h600));
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int rdy_at[3];
        busy_hold = 0;
        for (int i = 0; i < 3; i++) begin
            rdy_at[i] = 0;
            exp_q.push_back(mk(1'b0, 1'b0, 32'h800 + 32'(4 * i), 32'h0));
        end
        bus.imemaddr = 32'h800;
        bus.imemRen  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.i_ready && n < 3) begin
                rdy_at[n] = c;
                n++;
                if (n == 3) bus.imemRen = 1'b0;
                else        bus.imemaddr = bus.imemaddr + 32'd4;
            end
        end
        n_checks++;
        if (n !== 3 || rdy_at[0] !== 3)
            $display("FAIL b2b_first: got count=%0d at=%0d want 3 at 3", n, rdy_at[0]);
        else n_pass++;
        n_checks++;
        if (rdy_at[1] !== 7 || rdy_at[2] !== 11)
            $display("FAIL b2b_spacing: got %0d,%0d want 7,11", rdy_at[1], rdy_at[2]);
        else n_pass++;
        n_checks++;
        if (bus.imemload !== ram_val(32'h808))
            $display("FAIL b2b_load: got %h want %h", bus.imemload, ram_val(32'h808));
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int ir = 0;
        busy_hold = 5;
        exp_q.push_back(mk(1'b0, 1'b0, 32'h700, 32'h0));
        bus.imemaddr = 32'h700;
        bus.imemRen  = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.Ren !== 1'b1) $display("FAIL rstmid_active: got Ren=%b want 1", bus.Ren); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.Ren, bus.Wen, bus.i_ready, bus.d_ready, bus.timeout_err} !== 5'b0 ||
            bus.ramaddr !== 32'h0 || bus.ramstore !== 32'h0 ||
            bus.imemload !== 32'h0 || bus.dmmload !== 32'h0)
            $display("FAIL rstmid_outputs: got ctl=%b addr=%h store=%h i=%h d=%h want all 0",
                     {bus.Ren, bus.Wen, bus.i_ready, bus.d_ready, bus.timeout_err},
                     bus.ramaddr, bus.ramstore, bus.imemload, bus.dmmload);
        else n_pass++;
        n_checks++;
        if (dut.state !== 2'd0) $display("FAIL rstmid_state: got %0d want 0", dut.state); else n_pass++;
        bus.imemRen = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (bus.i_ready) ir++;
        end
        n_checks++;
        if (ir !== 0) $display("FAIL rstmid_ready: got %0d want 0", ir); else n_pass++;
    endtask

    task automatic test_timeout();
        int ren = 0;
        int dr  = 0;
        int dr_at = 0;
        exp_q.push_back(mk(1'b1, 1'b0, 32'h900, 32'h0));
        busy_stuck  = 1'b1;
        bus.dmmaddr = 32'h900;
        bus.dmmRen  = 1'b1;
`ifdef T02_MEM_ARB_TIMEOUT_EN
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.Ren) ren++;
            if (bus.d_ready) begin
                dr++;
                dr_at = c;
                bus.dmmRen = 1'b0;
            end
        end
        n_checks++;
        if (ren !== 8) $display("FAIL timeout_ren: got %0d want 8", ren); else n_pass++;
        n_checks++;
        if (dr !== 1 || dr_at !== 9) $display("FAIL timeout_ready: got count=%0d at=%0d want 1 at 9", dr, dr_at);
        else n_pass++;
        n_checks++;
        if (bus.dmmload !== 32'h0) $display("FAIL timeout_load: got %h want 0", bus.dmmload); else n_pass++;
        busy_stuck = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.timeout_err !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", bus.timeout_err); else n_pass++;
`else
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (bus.Ren) ren++;
            if (bus.d_ready) dr++;
        end
        n_checks++;
        if (ren !== 30 || bus.Ren !== 1'b1) $display("FAIL notimeout_ren: got %0d want 30", ren); else n_pass++;
        n_checks++;
        if (dr !== 0) $display("FAIL notimeout_ready: got %0d want 0", dr); else n_pass++;
        n_checks++;
        if (bus.timeout_err !== 1'b0) $display("FAIL notimeout_err: got %b want 0", bus.timeout_err); else n_pass++;
`endif
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.timeout_err !== 1'b0 || bus.Ren !== 1'b0)
            $display("FAIL timeout_reset: got err=%b Ren=%b want 0 0", bus.timeout_err, bus.Ren);
        else n_pass++;
        bus.dmmRen = 1'b0;
        busy_stuck = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.imemRen  = 1'b0;
        bus.imemaddr = '0;
        bus.dmmRen   = 1'b0;
        bus.dmmWen   = 1'b0;
        bus.dmmaddr  = '0;
        bus.dmmstore = '0;

        test_reset();
        test_fetch();
        test_simul_rw();
        test_write_latch();
        test_starvation();
        test_withdraw();
        test_back_to_back();
        test_reset_mid();
        test_timeout();

        n_checks++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
